// File: rtl/io_map_pkg.sv
// io_map_pkg
// Shared constants and types for the CPU I/O space.
//   IN_PORT_BASE  : first address of the input port window (F0-FF)
//   OUT_PORT_BASE : first address of the output port bank (E0-EF)
//   IO_PORT_COUNT : number of ports in each bank
//   io_data_t     : one 8-bit I/O port value, shared by both port banks
package io_map_pkg;

  localparam logic [7:0] IN_PORT_BASE  = 8'hF0;
  localparam logic [7:0] OUT_PORT_BASE = 8'hE0;
  localparam int         IO_PORT_COUNT = 16;

  typedef logic [7:0] io_data_t;

endpackage

// File: rtl/input_ports_if.sv
// input_ports_if
// CPU-facing read bus of the input port bank.
//   read_en      : CPU read strobe (master -> slave)
//   address      : CPU data address (master -> slave)
//   data_out     : registered read data (slave -> master)
//   port_changed : sticky per-port change flags (slave -> master)
//   irq          : level interrupt request (slave -> master)
interface input_ports_if;
  import io_map_pkg::*;

  logic        read_en;
  logic [7:0]  address;
  io_data_t    data_out;
  logic [15:0] port_changed;
  logic        irq;

  modport master (
    output read_en,
    output address,
    input  data_out,
    input  port_changed,
    input  irq
  );

  modport slave (
    input  read_en,
    input  address,
    output data_out,
    output port_changed,
    output irq
  );

endinterface

// File: rtl/bit_sync.sv
// bit_sync
// Generic multi-flop synchronizer for asynchronous inputs.
//   clk   : sampling clock
//   reset : synchronous active-high reset, clears every stage
//   d     : asynchronous input vector
//   q     : input after STAGES flops
module bit_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift chain: stage 0 takes the raw input, each later stage copies its
  // predecessor, so a change reaches q after STAGES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/input_ports.sv
// input_ports
// Memory-mapped read side of the CPU I/O space (BASE_ADDR .. BASE_ADDR+15).
//   clk                      : system clock
//   reset                    : synchronous active-high reset
//   bus                      : slave side of input_ports_if
//                              (read_en, address in; data_out, port_changed, irq out)
//   port_in_00 .. port_in_15 : asynchronous 8-bit external inputs
// Each port is synchronized, read back one cycle after a read hit, and
// watched for changes that set a sticky flag cleared by reading the port.
module input_ports
  import io_map_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = IN_PORT_BASE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input_ports_if.slave  bus,
  input  io_data_t      port_in_00,
  input  io_data_t      port_in_01,
  input  io_data_t      port_in_02,
  input  io_data_t      port_in_03,
  input  io_data_t      port_in_04,
  input  io_data_t      port_in_05,
  input  io_data_t      port_in_06,
  input  io_data_t      port_in_07,
  input  io_data_t      port_in_08,
  input  io_data_t      port_in_09,
  input  io_data_t      port_in_10,
  input  io_data_t      port_in_11,
  input  io_data_t      port_in_12,
  input  io_data_t      port_in_13,
  input  io_data_t      port_in_14,
  input  io_data_t      port_in_15
);

  localparam int NUM_PORTS = IO_PORT_COUNT;

  io_data_t                port_raw  [NUM_PORTS];
  io_data_t                sync_val  [NUM_PORTS];
  io_data_t                prev_val  [NUM_PORTS];
  logic                    hit;
  logic [3:0]              index;
  io_data_t                data_q;
  logic [NUM_PORTS-1:0]    changed_q;
  logic [NUM_PORTS-1:0]    changed_next;
  logic                    irq_q;

  assign port_raw[0]  = port_in_00;
  assign port_raw[1]  = port_in_01;
  assign port_raw[2]  = port_in_02;
  assign port_raw[3]  = port_in_03;
  assign port_raw[4]  = port_in_04;
  assign port_raw[5]  = port_in_05;
  assign port_raw[6]  = port_in_06;
  assign port_raw[7]  = port_in_07;
  assign port_raw[8]  = port_in_08;
  assign port_raw[9]  = port_in_09;
  assign port_raw[10] = port_in_10;
  assign port_raw[11] = port_in_11;
  assign port_raw[12] = port_in_12;
  assign port_raw[13] = port_in_13;
  assign port_raw[14] = port_in_14;
  assign port_raw[15] = port_in_15;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_sync
    bit_sync #(
      .WIDTH  ($bits(io_data_t)),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (port_raw[k]),
      .q     (sync_val[k])
    );
  end

  // The window comparison is done one bit wider so a base near FF cannot
  // wrap the upper bound; the index is the offset from the base, which
  // reduces to address[3:0] for a 16-aligned base.
  assign hit   = bus.read_en
               && (bus.address >= BASE_ADDR)
               && ({1'b0, bus.address} <= ({1'b0, BASE_ADDR} + 9'(NUM_PORTS - 1)));
  assign index = 4'(bus.address - BASE_ADDR);

  // A change seen this cycle sets the flag even if the same port is being
  // read, so no change can slip past between read and clear.
  always_comb begin
    changed_next = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      changed_next[k] = (sync_val[k] != prev_val[k])
                      | (changed_q[k] & ~(hit && (index == 4'(k))));
    end
  end

  // Read data, previous-value history, flags and irq all register together;
  // irq is computed from the next flag value so it moves with port_changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      changed_q <= '0;
      irq_q     <= 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) prev_val[k] <= '0;
    end else begin
      if (bus.read_en) data_q <= hit ? sync_val[index] : 8'h00;
      changed_q <= changed_next;
      irq_q     <= |changed_next;
      for (int k = 0; k < NUM_PORTS; k++) prev_val[k] <= sync_val[k];
    end
  end

  assign bus.data_out     = data_q;
  assign bus.port_changed = changed_q;
  assign bus.irq          = irq_q;

endmodule

// File: tb/tb_input_ports.sv
// tb_input_ports
// Directed self-checking bench for input_ports: drives the CPU read bus
// through the interface master side and the 16 external ports, and checks
// data_out, port_changed and irq against hand-computed values.
module tb_input_ports;
  import io_map_pkg::*;

  logic     clk;
  logic     reset;
  io_data_t port_in [16];
  int       vectors;
  int       miscompares;

  input_ports_if bus ();

  input_ports #(
    .BASE_ADDR   (8'hF0),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .port_in_00 (port_in[0]),
    .port_in_01 (port_in[1]),
    .port_in_02 (port_in[2]),
    .port_in_03 (port_in[3]),
    .port_in_04 (port_in[4]),
    .port_in_05 (port_in[5]),
    .port_in_06 (port_in[6]),
    .port_in_07 (port_in[7]),
    .port_in_08 (port_in[8]),
    .port_in_09 (port_in[9]),
    .port_in_10 (port_in[10]),
    .port_in_11 (port_in[11]),
    .port_in_12 (port_in[12]),
    .port_in_13 (port_in[13]),
    .port_in_14 (port_in[14]),
    .port_in_15 (port_in[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it, where outputs are sampled
  // and the next inputs are driven.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [7:0] addr);
    bus.read_en = rd;
    bus.address = addr;
  endtask

  task automatic checkOutput(input string tag, input io_data_t exp_data,
                             input logic [15:0] exp_changed, input logic exp_irq);
    vectors++;
    assert (bus.data_out === exp_data) else begin
      miscompares++;
      $error("[TB] FAIL %s data_out: got %h expected %h", tag, bus.data_out, exp_data);
    end
    vectors++;
    assert (bus.port_changed === exp_changed) else begin
      miscompares++;
      $error("[TB] FAIL %s port_changed: got %h expected %h", tag, bus.port_changed, exp_changed);
    end
    vectors++;
    assert (bus.irq === exp_irq) else begin
      miscompares++;
      $error("[TB] FAIL %s irq: got %b expected %b", tag, bus.irq, exp_irq);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 16; k++) port_in[k] = 8'h00;
    applyStimulus(1'b0, 8'h00);
    reset = 1'b1;
    tick(2);
    checkOutput("reset", 8'h00, 16'h0000, 1'b0);

    // Scenario 1: port 3 change, sync latency, flag and irq, then read.
    reset      = 1'b0;
    port_in[3] = 8'h5A;
    tick();
    checkOutput("s1_edge1", 8'h00, 16'h0000, 1'b0);
    tick();
    checkOutput("s1_edge2", 8'h00, 16'h0000, 1'b0);
    tick();
    checkOutput("s1_flag", 8'h00, 16'h0008, 1'b1);
    applyStimulus(1'b1, 8'hF3);
    tick();
    checkOutput("s1_read", 8'h5A, 16'h0000, 1'b0);

    // Scenario 2: re-read with no change, data stays, nothing flagged.
    tick();
    checkOutput("s2_reread", 8'h5A, 16'h0000, 1'b0);
    applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("s2_hold", 8'h5A, 16'h0000, 1'b0);

    // Scenario 3: read F7 in the very cycle the change on port 7 is seen.
    port_in[7] = 8'h33;
    tick(2);
    applyStimulus(1'b1, 8'hF7);
    tick();
    checkOutput("s3_setwins", 8'h33, 16'h0080, 1'b1);
    applyStimulus(1'b0, 8'hF7);

    // Scenario 4: read_en low holds, misses return zero and never clear.
    port_in[0] = 8'h21;
    tick(3);
    checkOutput("s4_flags", 8'h33, 16'h0081, 1'b1);
    applyStimulus(1'b1, 8'hF7);
    tick();
    checkOutput("s4_clr7", 8'h33, 16'h0001, 1'b1);
    applyStimulus(1'b0, 8'hF0);
    tick();
    checkOutput("s4_noread", 8'h33, 16'h0001, 1'b1);
    applyStimulus(1'b1, 8'hEF);
    tick();
    checkOutput("s4_missEF", 8'h00, 16'h0001, 1'b1);
    applyStimulus(1'b1, 8'h00);
    tick();
    checkOutput("s4_miss00", 8'h00, 16'h0001, 1'b1);
    applyStimulus(1'b1, 8'h80);
    tick();
    checkOutput("s4_miss80", 8'h00, 16'h0001, 1'b1);
    applyStimulus(1'b1, 8'hF0);
    tick();
    checkOutput("s4_readF0", 8'h21, 16'h0000, 1'b0);
    applyStimulus(1'b0, 8'h00);

    // Scenario 5: all ports change together, then back-to-back reads F0..FF.
    for (int k = 0; k < 16; k++) port_in[k] = 8'(k * 8'h11);
    tick(3);
    checkOutput("s5_allset", 8'h21, 16'hFFFF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      logic [15:0] remaining;
      remaining = 16'hFFFF << (k + 1);
      applyStimulus(1'b1, 8'(8'hF0 + k));
      tick();
      checkOutput($sformatf("s5_read%0d", k), 8'(k * 8'h11), remaining, k != 15);
    end
    applyStimulus(1'b0, 8'h00);

    // Scenario 6: reset with flags set and data_out=C3, read pending.
    port_in[5] = 8'hC3;
    tick(3);
    checkOutput("s6_flag5", 8'hFF, 16'h0020, 1'b1);
    applyStimulus(1'b1, 8'hF5);
    tick();
    checkOutput("s6_readC3", 8'hC3, 16'h0000, 1'b0);
    applyStimulus(1'b0, 8'h00);
    port_in[9] = 8'h5C;
    tick(3);
    checkOutput("s6_flag9", 8'hC3, 16'h0200, 1'b1);
    applyStimulus(1'b1, 8'hF9);
    reset = 1'b1;
    tick();
    checkOutput("s6_reset", 8'h00, 16'h0000, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("s6_post1", 8'h00, 16'h0000, 1'b0);
    tick();
    checkOutput("s6_post2", 8'h00, 16'h0000, 1'b0);
    tick();
    checkOutput("s6_resync", 8'h00, 16'hFFFE, 1'b1);
    applyStimulus(1'b1, 8'hF9);
    tick();
    checkOutput("s6_read9", 8'h5C, 16'hFDFE, 1'b1);
    applyStimulus(1'b0, 8'h00);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
